// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch slice.
//   fetch_state_t    : fetch sequencer states (IDLE, RUN)
//   INSTR_W          : instruction word width in bits
//   DEFAULT_RESET_PC : PC loaded on reset unless overridden by the top
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/imem_byte_ram.sv
// ---------------------------------------------------------------------------
// imem_byte_ram
// Byte-wide instruction memory with one byte write port and a combinational
// four-byte read. The four read bytes wrap modulo the memory depth, so a word
// starting near the top of memory continues from address 0.
// Contents are never reset.
//   clk     : write clock
//   wr_en   : write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr : byte write address
//   wr_data : byte write data
//   rd_addr : address of the first byte of the word
//   rd_data : assembled word, big- or little-endian per BIG_ENDIAN
// ---------------------------------------------------------------------------
module imem_byte_ram
  import fetch_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [7:0]         wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [ADDR_W-1:0] addr3;
  logic [7:0]        byte0;
  logic [7:0]        byte1;
  logic [7:0]        byte2;
  logic [7:0]        byte3;

  // Byte write port; no reset so program contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Address arithmetic stays ADDR_W bits wide, which gives the wrap for free.
  assign addr1 = rd_addr + ADDR_W'(1);
  assign addr2 = rd_addr + ADDR_W'(2);
  assign addr3 = rd_addr + ADDR_W'(3);

  // Asynchronous read: a write on the same edge is not yet visible, so a
  // fetch sampled on that edge sees the old byte.
  always_comb begin
    byte0   = mem[rd_addr];
    byte1   = mem[addr1];
    byte2   = mem[addr2];
    byte3   = mem[addr3];
    rd_data = BIG_ENDIAN ? {byte0, byte1, byte2, byte3}
                         : {byte3, byte2, byte1, byte0};
  end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Single-issue instruction fetch stage with a byte-loadable instruction
// memory. In RUN it fetches one word per free output slot, presents it with
// a one-cycle latency and advances the PC by 4. A redirect overrides
// everything: it reloads the PC and drops the current output.
//   clk, rst_n        : clock and asynchronous active-low reset
//   fetch_en          : fetching permitted (IDLE <-> RUN)
//   redirect_valid/pc : branch/jump target request
//   out_ready         : decode accepts the current output
//   out_valid         : out_instr/out_pc/out_pc_plus4/out_misaligned hold a word
//   out_instr         : fetched instruction word
//   out_pc            : address the word was fetched from
//   out_pc_plus4      : out_pc + 4 (32-bit wrap)
//   out_misaligned    : out_pc[1:0] != 0
//   wr_en/addr/data   : byte-write program load port
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W     = 8,
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_pc_plus4,
  output logic               out_misaligned,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [7:0]         wr_data
);

  fetch_state_t       state;
  logic [31:0]        pc;
  logic [INSTR_W-1:0] rd_word;
  logic               fetch_slot;

  imem_byte_ram #(
    .ADDR_W     (ADDR_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_imem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (pc[ADDR_W-1:0]),
    .rd_data (rd_word)
  );

  // A slot exists when the output register is empty or being drained now.
  assign fetch_slot = (state == RUN) && (!out_valid || out_ready);

  // Sequencer and output register. The state follows fetch_en every cycle,
  // so entering RUN costs one cycle before the first fetch. Redirect is
  // checked first so it wins over a fetch or a drain in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      out_valid      <= 1'b0;
      out_instr      <= '0;
      out_pc         <= '0;
      out_pc_plus4   <= '0;
      out_misaligned <= 1'b0;
    end else begin
      state <= fetch_en ? RUN : IDLE;
      if (redirect_valid) begin
        pc        <= redirect_pc;
        out_valid <= 1'b0;
      end else if (fetch_slot) begin
        out_instr      <= rd_word;
        out_pc         <= pc;
        out_pc_plus4   <= pc + 32'd4;
        out_misaligned <= |pc[1:0];
        out_valid      <= 1'b1;
        pc             <= pc + 32'd4;
      end else if (out_ready) begin
        // Word consumed with no refill behind it (IDLE).
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Drives two fetch_unit builds from the same inputs: d0 with defaults
// (big-endian, reset PC 0) and d1 little-endian with reset PC 0x8. A
// behavioural model of the fetch rules predicts both every cycle; directed
// literal checks pin the model to known words.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fetch_en;
  logic       redirect_valid;
  logic [31:0] redirect_pc;
  logic       out_ready;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  logic [1:0]       o_valid;
  logic [1:0][31:0] o_instr;
  logic [1:0][31:0] o_pc;
  logic [1:0][31:0] o_pc4;
  logic [1:0]       o_mis;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0]  mem [256];
  bit          m_run [2];
  bit          m_vld [2];
  logic [31:0] m_pc [2];
  logic [31:0] m_instr [2];
  logic [31:0] m_opc [2];
  bit          m_mis [2];

  always #5 clk = ~clk;

  fetch_unit dut0 (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_ready      (out_ready),
    .out_valid      (o_valid[0]),
    .out_instr      (o_instr[0]),
    .out_pc         (o_pc[0]),
    .out_pc_plus4   (o_pc4[0]),
    .out_misaligned (o_mis[0]),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data)
  );

  fetch_unit #(
    .ADDR_W     (8),
    .RESET_PC   (32'h0000_0008),
    .BIG_ENDIAN (1'b0)
  ) dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_ready      (out_ready),
    .out_valid      (o_valid[1]),
    .out_instr      (o_instr[1]),
    .out_pc         (o_pc[1]),
    .out_pc_plus4   (o_pc4[1]),
    .out_misaligned (o_mis[1]),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data)
  );

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Full output check of one instance against a hand-computed word.
  task automatic checkWord(input int i, input string tag, input logic [31:0] instr,
                           input logic [31:0] pc);
    checkOutput($sformatf("%s.d%0d.valid", tag, i), 32'(o_valid[i]), 32'd1);
    checkOutput($sformatf("%s.d%0d.instr", tag, i), o_instr[i], instr);
    checkOutput($sformatf("%s.d%0d.pc", tag, i), o_pc[i], pc);
    checkOutput($sformatf("%s.d%0d.pc4", tag, i), o_pc4[i], pc + 32'd4);
    checkOutput($sformatf("%s.d%0d.mis", tag, i), 32'(o_mis[i]), 32'(pc[1:0] != 2'b00));
  endtask

  task automatic checkZero(input string tag);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("%s.d%0d.valid", tag, i), 32'(o_valid[i]), 32'd0);
      checkOutput($sformatf("%s.d%0d.instr", tag, i), o_instr[i], 32'd0);
      checkOutput($sformatf("%s.d%0d.pc", tag, i), o_pc[i], 32'd0);
      checkOutput($sformatf("%s.d%0d.pc4", tag, i), o_pc4[i], 32'd0);
      checkOutput($sformatf("%s.d%0d.mis", tag, i), 32'(o_mis[i]), 32'd0);
    end
  endtask

  // Advance to just after the next falling edge; inputs change here.
  task automatic applyStimulus();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] wordAt(input logic [31:0] a, input bit be);
    logic [7:0] b [4];
    for (int k = 0; k < 4; k++) b[k] = mem[8'(a + 32'(k))];
    return be ? {b[0], b[1], b[2], b[3]} : {b[3], b[2], b[1], b[0]};
  endfunction

  // Behavioural model: per rising edge, apply redirect, fetch or drain from
  // the rules; the fetched word comes from the byte array before any write
  // of the same edge lands.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_run[i]   = 1'b0;
        m_vld[i]   = 1'b0;
        m_pc[i]    = (i == 0) ? 32'h0 : 32'h8;
        m_instr[i] = 32'h0;
        m_opc[i]   = 32'h0;
        m_mis[i]   = 1'b0;
      end else begin
        if (redirect_valid) begin
          m_pc[i]  = redirect_pc;
          m_vld[i] = 1'b0;
        end else if (m_run[i] && (!m_vld[i] || out_ready)) begin
          m_instr[i] = wordAt(m_pc[i], i == 0);
          m_opc[i]   = m_pc[i];
          m_mis[i]   = (m_pc[i] % 4) != 0;
          m_vld[i]   = 1'b1;
          m_pc[i]    = m_pc[i] + 32'd4;
        end else if (out_ready) begin
          m_vld[i] = 1'b0;
        end
        m_run[i] = fetch_en;
      end
    end
    if (wr_en) mem[wr_addr] = wr_data;
  end

  // Compare process: every falling edge, DUT outputs vs. model.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkZero("rst");
    end else begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("mdl.d%0d.valid", i), 32'(o_valid[i]), 32'(m_vld[i]));
        if (m_vld[i]) begin
          checkOutput($sformatf("mdl.d%0d.instr", i), o_instr[i], m_instr[i]);
          checkOutput($sformatf("mdl.d%0d.pc", i), o_pc[i], m_opc[i]);
          checkOutput($sformatf("mdl.d%0d.pc4", i), o_pc4[i], m_opc[i] + 32'd4);
          checkOutput($sformatf("mdl.d%0d.mis", i), 32'(o_mis[i]), 32'(m_mis[i]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    out_ready = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    applyStimulus();
    applyStimulus();
    checkZero("reset");
    rst_n = 1'b1;

    // Program load: 00..0F = index, FE/FF = AA/BB, rest random
    for (int a = 0; a < 256; a++) begin
      wr_en   = 1'b1;
      wr_addr = 8'(a);
      wr_data = (a < 16) ? 8'(a) : (a == 254) ? 8'hAA : (a == 255) ? 8'hBB : 8'($urandom);
      applyStimulus();
    end
    wr_en = 1'b0;

    // Sequential stream from 0
    redirect_valid = 1'b1; redirect_pc = 32'h0; out_ready = 1'b1;
    applyStimulus();
    redirect_valid = 1'b0; fetch_en = 1'b1;
    applyStimulus();
    checkOutput("seq.start.valid", 32'(o_valid[0]), 32'd0);
    applyStimulus();
    checkWord(0, "seq0", 32'h00010203, 32'h0);
    checkWord(1, "seq0", 32'h03020100, 32'h0);
    applyStimulus();
    checkWord(0, "seq1", 32'h04050607, 32'h4);
    checkWord(1, "seq1", 32'h07060504, 32'h4);
    applyStimulus();
    checkWord(0, "seq2", 32'h08090A0B, 32'h8);

    // Redirect to 0x0C: bubble then target word
    redirect_valid = 1'b1; redirect_pc = 32'h0C;
    applyStimulus();
    checkOutput("redir.bubble.valid", 32'(o_valid[0]), 32'd0);
    redirect_valid = 1'b0;
    applyStimulus();
    checkWord(0, "redir", 32'h0C0D0E0F, 32'h0C);

    // Back-pressure: three stalled cycles hold the first word
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    applyStimulus();
    redirect_valid = 1'b0;
    applyStimulus();
    checkWord(0, "stall0", 32'h00010203, 32'h0);
    out_ready = 1'b0;
    repeat (3) begin
      applyStimulus();
      checkWord(0, "stall", 32'h00010203, 32'h0);
    end
    out_ready = 1'b1;
    applyStimulus();
    checkWord(0, "release", 32'h04050607, 32'h4);

    // Wrapped misaligned fetch at 0xFE
    fetch_en = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("drain.valid", 32'(o_valid[0]), 32'd0);
    wr_en = 1'b1; wr_addr = 8'h00; wr_data = 8'hCC;
    applyStimulus();
    wr_addr = 8'h01; wr_data = 8'hDD;
    applyStimulus();
    wr_en = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'hFE; fetch_en = 1'b1;
    applyStimulus();
    redirect_valid = 1'b0;
    applyStimulus();
    checkWord(0, "wrap", 32'hAABBCCDD, 32'hFE);
    checkOutput("wrap.pc4", o_pc4[0], 32'h102);
    checkWord(1, "wrap", 32'hDDCCBBAA, 32'hFE);
    applyStimulus();
    checkWord(0, "wrap2", 32'h02030405, 32'h102);
    checkWord(1, "wrap2", 32'h05040302, 32'h102);

    // Reset during a stall
    out_ready = 1'b0;
    applyStimulus();
    checkWord(0, "prerst", 32'h02030405, 32'h102);
    rst_n = 1'b0;
    #1;
    checkZero("asyncrst");
    applyStimulus();
    rst_n = 1'b1; out_ready = 1'b1;
    k = 0;
    while (!o_valid[1] && k < 10) begin
      applyStimulus();
      k++;
    end
    checkOutput("postrst.timeout", 32'(o_valid[1]), 32'd1);
    checkWord(1, "postrst", 32'h0B0A0908, 32'h8);
    checkWord(0, "postrst", 32'hCCDD0203, 32'h0);

    // Randomized traffic checked by the model
    for (int n = 0; n < 3000; n++) begin
      fetch_en       = ($urandom_range(0, 9) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
      wr_en          = ($urandom_range(0, 5) == 0);
      wr_addr        = 8'($urandom);
      wr_data        = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        wr_en = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
      end
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
